// File: rtl/tcdm_arb_pkg.sv
// Shared types, constants and helpers for the TCDM round-robin arbiter.
// The default field widths below match the default arbiter configuration.
package tcdm_arb_pkg;

    localparam int unsigned STALL_CNT_W = 32'd32;
    localparam int unsigned TCDM_AW     = 32'd32;
    localparam int unsigned TCDM_DW     = 32'd32;

    typedef struct packed {
        logic [TCDM_AW-1:0]   add;
        logic                 wen;
        logic [TCDM_DW/8-1:0] be;
        logic [TCDM_DW-1:0]   data;
    } tcdm_req_t;

    typedef struct packed {
        logic [TCDM_DW-1:0] r_data;
        logic               r_valid;
    } tcdm_rsp_t;

    // Width of a requester index; at least one bit even for a single requester.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    // Next index in round-robin order, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/tcdm_arb_checker.sv
// Protocol checks for the TCDM arbiter: a locked requester must hold its
// request until granted, the slave must not answer with nothing outstanding,
// and the ID FIFO occupancy must stay within its depth.
module tcdm_arb_checker #(
    parameter int unsigned MAX_OUT = 32'd4,
    parameter int unsigned CNT_W   = 32'd3
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic             lock_drop_i,
    input logic             orphan_rsp_i,
    input logic [CNT_W-1:0] fifo_count_i
);

    // Sample the protocol conditions once per cycle outside reset.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            a_lock_held: assert (!lock_drop_i)
                else $error("tcdm_rr_arbiter: locked requester dropped req before grant");
            a_rsp_expected: assert (!orphan_rsp_i)
                else $error("tcdm_rr_arbiter: slave response with empty ID FIFO dropped");
            a_count_bound: assert (fifo_count_i <= CNT_W'(MAX_OUT))
                else $error("tcdm_rr_arbiter: ID FIFO occupancy above depth");
        end
    end

endmodule

// File: rtl/tcdm_arb_id_fifo.sv
// Synchronous FIFO of requester IDs, one entry per granted-but-unanswered
// transaction. Head is the requester owed the next in-order slave response.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module tcdm_arb_id_fifo #(
    parameter int unsigned DEPTH = 32'd4,
    parameter int unsigned ID_W  = 32'd1,
    parameter int unsigned CNT_W = $clog2(DEPTH + 32'd1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [ID_W-1:0]  id_i,
    input  logic             pop_i,
    output logic [ID_W-1:0]  head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 32'd1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s, pop_s;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy next-state; simultaneous push and pop keep the count.
    always_comb begin
        push_s   = push_i & ~full_o;
        pop_s    = pop_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ID storage; cleared on reset so the head never carries stale contents.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ID_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= id_i;
        end
    end

endmodule

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM slave port between NR requesters.
// The request path is combinational; a stalled selection is locked until the
// slave grants, and responses are steered back through an in-order ID FIFO.
// Optional feature macro: TCDM_ARB_PERF_CNT_EN adds per-requester stall
// counters (stall_cnt_o) with a clear input (cnt_clear_i).
module tcdm_rr_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int unsigned NR      = 32'd2,
    parameter int unsigned AW      = 32'd32,
    parameter int unsigned DW      = 32'd32,
    parameter int unsigned MAX_OUT = 32'd4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NR-1:0]               m_req_i,
    output logic [NR-1:0]               m_gnt_o,
    input  logic [NR*AW-1:0]            m_add_i,
    input  logic [NR-1:0]               m_wen_i,
    input  logic [NR*(DW/8)-1:0]        m_be_i,
    input  logic [NR*DW-1:0]            m_data_i,
    output logic [NR*DW-1:0]            m_r_data_o,
    output logic [NR-1:0]               m_r_valid_o,
    output logic                        s_req_o,
    input  logic                        s_gnt_i,
    output logic [AW-1:0]               s_add_o,
    output logic                        s_wen_o,
    output logic [DW/8-1:0]             s_be_o,
    output logic [DW-1:0]               s_data_o,
    input  logic [DW-1:0]               s_r_data_i,
`ifdef TCDM_ARB_PERF_CNT_EN
    output logic [NR*STALL_CNT_W-1:0]   stall_cnt_o,
    input  logic                        cnt_clear_i,
`endif
    input  logic                        s_r_valid_i
);

    localparam int unsigned IDW   = id_width(NR);
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 32'd1);
    localparam int unsigned BW    = DW / 32'd8;

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             lock_vld_q, lock_vld_d;
    logic [IDW-1:0]   lock_id_q, lock_id_d;
    logic [IDW-1:0]   search_id_s;
    logic             search_found_s;
    logic             lock_hit_s;
    logic             lock_drop_s;
    logic [IDW-1:0]   win_s;
    logic             s_req_s;
    logic             hs_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [IDW-1:0]   head_s;
    logic [CNT_W-1:0] fifo_count_s;

    // First requesting index at or above the round-robin pointer, wrapping.
    always_comb begin
        int unsigned idx_v;
        search_found_s = 1'b0;
        search_id_s    = ptr_q;
        idx_v          = 32'd0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx_v = (32'(ptr_q) + k) % NR;
            if (!search_found_s && m_req_i[idx_v]) begin
                search_found_s = 1'b1;
                search_id_s    = IDW'(idx_v);
            end else begin
                search_found_s = search_found_s;
            end
        end
    end

    // A held lock wins only while its requester still asks; a dropped request
    // releases it and the normal search takes over in the same cycle.
    assign lock_hit_s  = lock_vld_q & m_req_i[lock_id_q];
    assign lock_drop_s = lock_vld_q & ~m_req_i[lock_id_q];
    assign win_s       = lock_hit_s ? lock_id_q : search_id_s;

    // A full FIFO blocks the request even if a response pops in the same cycle.
    assign s_req_s = rst_ni & (|m_req_i) & ~fifo_full_s;
    assign hs_s    = s_req_s & s_gnt_i;
    assign pop_s   = rst_ni & s_r_valid_i & ~fifo_empty_s;

    assign s_req_o    = s_req_s;
    assign s_add_o    = m_add_i[win_s*AW +: AW];
    assign s_wen_o    = m_wen_i[win_s];
    assign s_be_o     = m_be_i[win_s*BW +: BW];
    assign s_data_o   = m_data_i[win_s*DW +: DW];
    assign m_r_data_o = {NR{s_r_data_i}};

    // One-hot grant to the winner and one-hot response valid to the FIFO head.
    always_comb begin
        m_gnt_o     = {NR{1'b0}};
        m_r_valid_o = {NR{1'b0}};
        for (int unsigned i = 0; i < NR; i++) begin
            if (hs_s && (win_s == IDW'(i))) begin
                m_gnt_o[i] = 1'b1;
            end else begin
                m_gnt_o[i] = 1'b0;
            end
            if (pop_s && (head_s == IDW'(i))) begin
                m_r_valid_o[i] = 1'b1;
            end else begin
                m_r_valid_o[i] = 1'b0;
            end
        end
    end

    // Advance the pointer past an accepted winner; lock the winner while stalled.
    always_comb begin
        ptr_d      = ptr_q;
        lock_vld_d = 1'b0;
        lock_id_d  = lock_id_q;
        if (hs_s) begin
            ptr_d      = IDW'(rr_next(32'(win_s), NR));
            lock_vld_d = 1'b0;
        end else if (s_req_s) begin
            lock_vld_d = 1'b1;
            lock_id_d  = win_s;
        end else begin
            lock_vld_d = 1'b0;
        end
    end

    // Arbitration state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= {IDW{1'b0}};
            lock_vld_q <= 1'b0;
            lock_id_q  <= {IDW{1'b0}};
        end else begin
            ptr_q      <= ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
        end
    end

    tcdm_arb_id_fifo #(
        .DEPTH (MAX_OUT),
        .ID_W  (IDW),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs_s),
        .id_i    (win_s),
        .pop_i   (pop_s),
        .head_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    tcdm_arb_checker #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_checker (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lock_drop_i  (lock_drop_s),
        .orphan_rsp_i (s_r_valid_i & fifo_empty_s),
        .fifo_count_i (fifo_count_s)
    );

`ifdef TCDM_ARB_PERF_CNT_EN
    logic [NR*STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating per-requester stall count; clear takes priority over counting.
    always_comb begin
        logic [STALL_CNT_W-1:0] cnt_v;
        stall_cnt_d = stall_cnt_q;
        cnt_v       = {STALL_CNT_W{1'b0}};
        for (int unsigned i = 0; i < NR; i++) begin
            cnt_v = stall_cnt_q[i*STALL_CNT_W +: STALL_CNT_W];
            if (cnt_clear_i) begin
                cnt_v = {STALL_CNT_W{1'b0}};
            end else if (m_req_i[i] && !m_gnt_o[i] && (cnt_v != {STALL_CNT_W{1'b1}})) begin
                cnt_v = cnt_v + STALL_CNT_W'(1'b1);
            end else begin
                cnt_v = cnt_v;
            end
            stall_cnt_d[i*STALL_CNT_W +: STALL_CNT_W] = cnt_v;
        end
    end

    // Stall counter registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= {(NR*STALL_CNT_W){1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
